// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues reads at the current PC, latches the
// instruction for decode, and drives PC advance/redirect loads back to the PC register.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int PC_STEP = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] in_pc,
    output logic              en_pc,
    output logic              fetch_err
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        ERR
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] fetch_pc;

    // The PC register commits a load on the same edge we start a request, so
    // while en_pc is high the address to fetch is in_pc, not the stale pc.
    assign fetch_pc = en_pc ? in_pc : pc;

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch below sees the pre-edge values of state, en_pc and in_pc.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            in_pc     <= '0;
            en_pc     <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            en_pc <= 1'b0;
            if (redirect && state != ERR) begin
                en_pc     <= 1'b1;
                in_pc     <= redirect_pc;
                ir_valid  <= 1'b0;
                mem_rd_en <= 1'b0;
                wait_cnt  <= '0;
                state     <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state     <= REQ;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= fetch_pc;
                        wait_cnt  <= '0;
                    end
                    REQ: begin
                        if (mem_ready) begin
                            ir        <= mem_rdata;
                            ir_valid  <= 1'b1;
                            en_pc     <= 1'b1;
                            in_pc     <= pc + ADDR_W'(PC_STEP);
                            mem_rd_en <= 1'b0;
                            wait_cnt  <= '0;
                            state     <= HOLD;
                        end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                            fetch_err <= 1'b1;
                            mem_rd_en <= 1'b0;
                            state     <= ERR;
                        end else begin
                            wait_cnt <= wait_cnt + CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (ir_ack) begin
                            ir_valid  <= 1'b0;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= fetch_pc;
                            wait_cnt  <= '0;
                            state     <= REQ;
                        end
                    end
                    ERR: begin
                        state <= ERR;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, hand-written timeout and
// reset sequences, then randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc = '0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] ir;
    logic        ir_valid;
    logic        ir_ack;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] in_pc;
    logic        en_pc;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit #(
        .ADDR_W(16), .DATA_W(16), .PC_STEP(1), .TIMEOUT(15)
    ) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .ir(ir), .ir_valid(ir_valid), .ir_ack(ir_ack),
        .redirect(redirect), .redirect_pc(redirect_pc), .in_pc(in_pc),
        .en_pc(en_pc), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    // Behavioural PC register fed by the fetch unit.
    always @(posedge clk) begin
        if (reset) pc <= '0;
        else if (en_pc) pc <= in_pc;
    end

    typedef struct {
        logic        rst, rdy;
        logic [15:0] rdata;
        logic        ack, redir;
        logic [15:0] rpc;
        logic        e_rd_en;
        logic [15:0] e_addr, e_ir;
        logic        e_irv, e_en;
        logic [15:0] e_inpc;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic rdy, input logic [15:0] rdata,
                         input logic ack, input logic redir, input logic [15:0] rpc);
        @(negedge clk);
        reset = rst; mem_ready = rdy; mem_rdata = rdata;
        ir_ack = ack; redirect = redir; redirect_pc = rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic rst, rdy, input logic [15:0] rdata, input logic ack, redir,
                       input logic [15:0] rpc, input logic e_rd_en, input logic [15:0] e_addr,
                       input logic [15:0] e_ir, input logic e_irv, e_en,
                       input logic [15:0] e_inpc, input logic e_err);
        vecs.push_back('{rst, rdy, rdata, ack, redir, rpc, e_rd_en, e_addr, e_ir, e_irv,
                         e_en, e_inpc, e_err});
    endtask

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Transaction-level model state for the random phase.
    bit          out_m, held_m, restart_m, exp_en, last_en;
    logic [15:0] exp_addr, exp_ir, exp_in;
    int          waitc;

    initial begin
        reset = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
        ir_ack = 1'b0; redirect = 1'b0; redirect_pc = '0;

        // rst rdy rdata ack redir rpc | rd_en addr ir irv en in_pc err
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        add(0, 1, 16'hBEEF, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        add(0, 1, 16'h1234, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 1, 16'h0001, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h1234, 1, 0, 16'h0001, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0001, 16'h1234, 0, 0, 16'h0001, 0);
        for (int i = 0; i < 3; i++)
            add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0001, 16'h1234, 0, 0, 16'h0001, 0);
        add(0, 1, 16'h5678, 0, 0, 16'h0000, 0, 16'h0001, 16'h5678, 1, 1, 16'h0002, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0002, 16'h5678, 0, 0, 16'h0002, 0);
        add(0, 1, 16'h9ABC, 0, 0, 16'h0000, 0, 16'h0002, 16'h9ABC, 1, 1, 16'h0003, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 16'h9ABC, 1, 0, 16'h0003, 0);
        add(0, 0, 16'h0000, 1, 1, 16'h0040, 0, 16'h0002, 16'h9ABC, 0, 1, 16'h0040, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0040, 16'h9ABC, 0, 0, 16'h0040, 0);
        add(0, 1, 16'h0BAD, 0, 0, 16'h0000, 0, 16'h0040, 16'h0BAD, 1, 1, 16'h0041, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0041, 16'h0BAD, 0, 0, 16'h0041, 0);
        add(0, 1, 16'hDEAD, 0, 1, 16'hFFFF, 0, 16'h0041, 16'h0BAD, 0, 1, 16'hFFFF, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'hFFFF, 16'h0BAD, 0, 0, 16'hFFFF, 0);
        add(0, 1, 16'h7777, 0, 0, 16'h0000, 0, 16'hFFFF, 16'h7777, 1, 1, 16'h0000, 0);
        add(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h0000, 16'h7777, 0, 0, 16'h0000, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'h7777, 0, 0, 16'h0000, 0);
        add(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);
        add(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].rdata, vecs[i].ack, vecs[i].redir, vecs[i].rpc);
            tick();
            check($sformatf("v%0d_rd_en", i), mem_rd_en, vecs[i].e_rd_en);
            check($sformatf("v%0d_addr", i),  mem_addr,  vecs[i].e_addr);
            check($sformatf("v%0d_ir", i),    ir,        vecs[i].e_ir);
            check($sformatf("v%0d_irv", i),   ir_valid,  vecs[i].e_irv);
            check($sformatf("v%0d_en", i),    en_pc,     vecs[i].e_en);
            check($sformatf("v%0d_in_pc", i), in_pc,     vecs[i].e_inpc);
            check($sformatf("v%0d_err", i),   fetch_err, vecs[i].e_err);
        end

        // Timeout: REQ entered by the last vector; 15 REQ cycles without mem_ready.
        for (int i = 1; i <= 15; i++) begin
            drive(0, 0, 16'h0000, 0, 0, 16'h0000);
            tick();
            check($sformatf("to%0d_err", i),   fetch_err, (i == 15));
            check($sformatf("to%0d_rd_en", i), mem_rd_en, (i != 15));
            check($sformatf("to%0d_en", i),    en_pc,     1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 16'h4321, 1, 1, 16'h1111);
            tick();
            check("err_sticky", fetch_err, 1'b1);
            check("err_no_en",  en_pc,     1'b0);
            check("err_no_req", mem_rd_en, 1'b0);
            check("err_ir",     ir,        16'h0000);
            check("err_in_pc",  in_pc,     16'h0000);
        end
        drive(1, 0, 16'h0000, 0, 0, 16'h0000);
        tick();
        check("err_reset_err", fetch_err, 1'b0);
        check("err_reset_req", mem_rd_en, 1'b0);
        drive(0, 0, 16'h0000, 0, 0, 16'h0000);
        tick();
        check("post_err_req",  mem_rd_en, 1'b1);
        check("post_err_addr", mem_addr,  16'h0000);

        // Randomized traffic.
        drive(1, 0, 16'h0000, 0, 0, 16'h0000);
        tick();
        out_m = 0; held_m = 0; restart_m = 1; last_en = 0;
        exp_addr = '0; exp_ir = '0; exp_in = '0; waitc = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, m, a;
            logic [15:0] rpc;
            r   = !last_en && ($urandom_range(0, 15) == 0);
            rpc = 16'($urandom);
            m   = (waitc >= 8) || ($urandom_range(0, 1) == 1);
            a   = ($urandom_range(0, 2) != 0);
            drive(0, m, 16'h0000, a, r, rpc);
            mem_rdata = mem_fn(mem_addr);
            tick();

            exp_en = 0;
            if (r) begin
                exp_en = 1; exp_in = rpc; exp_addr = rpc;
                held_m = 0; out_m = 0; restart_m = 1;
            end else if (restart_m) begin
                restart_m = 0; out_m = 1;
            end else if (out_m && m) begin
                exp_ir = mem_fn(exp_addr); exp_en = 1; exp_in = exp_addr + 16'd1;
                exp_addr = exp_addr + 16'd1; held_m = 1; out_m = 0;
            end else if (held_m && a) begin
                held_m = 0; out_m = 1;
            end
            waitc   = out_m ? waitc + 1 : 0;
            last_en = exp_en;

            check("rnd_rd_en", mem_rd_en, out_m);
            if (out_m) check("rnd_addr", mem_addr, exp_addr);
            check("rnd_irv", ir_valid, held_m);
            if (held_m) check("rnd_ir", ir, exp_ir);
            check("rnd_en", en_pc, exp_en);
            if (exp_en) check("rnd_in_pc", in_pc, exp_in);
            check("rnd_err", fetch_err, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
